// File: rtl/rv32_pkg.sv
// Shared constants for the RV32I decode stage: ALU op encoding, operand selects,
// opcode/funct3 values and the decoded-field bundle held in the output register.
package rv32_pkg;

  typedef enum logic [3:0] {
    ALU_ADD_SUB = 4'd0,
    ALU_SLL     = 4'd1,
    ALU_SLT     = 4'd2,
    ALU_SLTU    = 4'd3,
    ALU_XOR     = 4'd4,
    ALU_SRL_SRA = 4'd5,
    ALU_OR      = 4'd6,
    ALU_AND     = 4'd7,
    ALU_SRC1P4  = 4'd8,
    ALU_SRC2    = 4'd9
  } alu_op_e;

  localparam logic SRC1_RS1 = 1'b0;
  localparam logic SRC1_PC  = 1'b1;
  localparam logic SRC2_RS2 = 1'b0;
  localparam logic SRC2_IMM = 1'b1;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_JALR    = 3'b000;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_write;
    alu_op_e     alu_op;
    logic        sub_sra;
    logic        src1;
    logic        src2;
    logic [31:0] imm;
    logic        mem_load;
    logic        mem_store;
    logic        branch;
    logic        jump;
  } dec_t;

  // The arithmetic funct3 field is the low three bits of the ALU op encoding.
  function automatic alu_op_e funct3_op(input logic [2:0] f3);
    return alu_op_e'({1'b0, f3});
  endfunction

endpackage

// File: rtl/rv32_decode_if.sv
// Fetch-side and execute-side handshake/data bundle of the decode stage.
// illegal_out exists only when RV32_DECODE_ILLEGAL_EN is defined.
interface rv32_decode_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic        flush_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] pc_out;
  logic [4:0]  rs1_out;
  logic [4:0]  rs2_out;
  logic [4:0]  rd_out;
  logic        rd_write_out;
  logic [3:0]  alu_op_out;
  logic        alu_sub_sra_out;
  logic        alu_src1_out;
  logic        alu_src2_out;
  logic [31:0] imm_out;
  logic        mem_load_out;
  logic        mem_store_out;
  logic        branch_out;
  logic        jump_out;
`ifdef RV32_DECODE_ILLEGAL_EN
  logic        illegal_out;
`endif

  modport master (
    output in_valid, instr_in, pc_in, flush_in, out_ready,
    input  in_ready, out_valid, pc_out, rs1_out, rs2_out, rd_out, rd_write_out,
           alu_op_out, alu_sub_sra_out, alu_src1_out, alu_src2_out, imm_out,
           mem_load_out, mem_store_out, branch_out, jump_out
`ifdef RV32_DECODE_ILLEGAL_EN
    , input illegal_out
`endif
  );

  modport slave (
    input  in_valid, instr_in, pc_in, flush_in, out_ready,
    output in_ready, out_valid, pc_out, rs1_out, rs2_out, rd_out, rd_write_out,
           alu_op_out, alu_sub_sra_out, alu_src1_out, alu_src2_out, imm_out,
           mem_load_out, mem_store_out, branch_out, jump_out
`ifdef RV32_DECODE_ILLEGAL_EN
    , output illegal_out
`endif
  );
endinterface

// File: rtl/rv32_imm_gen.sv
// Combinational RV32I immediate extraction; the format is chosen from the opcode.
// Formats without an immediate (OP, unknown) yield zero.
module rv32_imm_gen
  import rv32_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (instr[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR:
        imm = {{20{instr[31]}}, instr[31:20]};
      OPC_STORE:
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OPC_BRANCH:
        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm = {instr[31:12], 12'b0};
      OPC_JAL:
        imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

endmodule

// File: rtl/rv32_decode.sv
// Registered RV32I decode stage with a single valid/ready output slot and flush.
// Optional illegal-instruction flag under RV32_DECODE_ILLEGAL_EN.
module rv32_decode
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset_n,
  rv32_decode_if.slave  bus
);

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1_f;
  logic [4:0]  rs2_f;
  logic [4:0]  rd_f;
  logic [31:0] imm;
  logic        bad;
  dec_t        dec;
  dec_t        q;
  logic        valid_q;
  logic [31:0] pc_q;
  logic        in_ready;
`ifdef RV32_DECODE_ILLEGAL_EN
  logic        illegal_q;
`endif

  assign instr  = bus.instr_in;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rs1_f  = instr[19:15];
  assign rs2_f  = instr[24:20];
  assign rd_f   = instr[11:7];

  rv32_imm_gen u_imm_gen (
    .instr (instr),
    .imm   (imm)
  );

  always_comb begin
    dec        = '0;
    dec.alu_op = ALU_ADD_SUB;
    bad        = 1'b0;
    case (opcode)
      OPC_LUI: begin
        dec.rd       = rd_f;
        dec.rd_write = |rd_f;
        dec.alu_op   = ALU_SRC2;
        dec.src2     = SRC2_IMM;
        dec.imm      = imm;
      end
      OPC_AUIPC: begin
        dec.rd       = rd_f;
        dec.rd_write = |rd_f;
        dec.src1     = SRC1_PC;
        dec.src2     = SRC2_IMM;
        dec.imm      = imm;
      end
      OPC_JAL: begin
        dec.rd       = rd_f;
        dec.rd_write = |rd_f;
        dec.alu_op   = ALU_SRC1P4;
        dec.src1     = SRC1_PC;
        dec.jump     = 1'b1;
        dec.imm      = imm;
      end
      OPC_JALR: begin
        dec.rs1      = rs1_f;
        dec.rd       = rd_f;
        dec.rd_write = |rd_f;
        dec.alu_op   = ALU_SRC1P4;
        dec.src1     = SRC1_PC;
        dec.jump     = 1'b1;
        dec.imm      = imm;
        bad          = (funct3 != F3_JALR);
      end
      OPC_BRANCH: begin
        dec.rs1    = rs1_f;
        dec.rs2    = rs2_f;
        dec.branch = 1'b1;
        dec.imm    = imm;
        case (funct3)
          F3_BEQ, F3_BNE: begin
            dec.alu_op  = ALU_ADD_SUB;
            dec.sub_sra = 1'b1;
          end
          F3_BLT, F3_BGE:   dec.alu_op = ALU_SLT;
          F3_BLTU, F3_BGEU: dec.alu_op = ALU_SLTU;
          default:          bad = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.rs1      = rs1_f;
        dec.rd       = rd_f;
        dec.rd_write = |rd_f;
        dec.src2     = SRC2_IMM;
        dec.mem_load = 1'b1;
        dec.imm      = imm;
        case (funct3)
          F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: bad = 1'b0;
          default:                             bad = 1'b1;
        endcase
      end
      OPC_STORE: begin
        dec.rs1       = rs1_f;
        dec.rs2       = rs2_f;
        dec.src2      = SRC2_IMM;
        dec.mem_store = 1'b1;
        dec.imm       = imm;
        case (funct3)
          F3_SB, F3_SH, F3_SW: bad = 1'b0;
          default:             bad = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        dec.rs1      = rs1_f;
        dec.rd       = rd_f;
        dec.rd_write = |rd_f;
        dec.alu_op   = funct3_op(funct3);
        dec.src2     = SRC2_IMM;
        dec.imm      = imm;
        // Only the shift forms reuse the upper immediate bits as funct7.
        if (funct3 == F3_SLL) begin
          bad = (funct7 != 7'h00);
        end else if (funct3 == F3_SRL_SRA) begin
          bad         = (funct7 != 7'h00) && (funct7 != 7'h20);
          dec.sub_sra = instr[30];
        end
      end
      OPC_OP: begin
        dec.rs1      = rs1_f;
        dec.rs2      = rs2_f;
        dec.rd       = rd_f;
        dec.rd_write = |rd_f;
        dec.alu_op   = funct3_op(funct3);
        dec.src2     = SRC2_RS2;
        if (funct7 == 7'h20 && (funct3 == F3_ADD_SUB || funct3 == F3_SRL_SRA)) begin
          dec.sub_sra = 1'b1;
        end else if (funct7 != 7'h00) begin
          bad = 1'b1;
        end
      end
      default: bad = 1'b1;
    endcase
    // Anything undecodable becomes ADDI x0,x0,0 so later stages see a harmless bubble.
    if (bad) begin
      dec      = '0;
      dec.src1 = SRC1_RS1;
      dec.src2 = SRC2_IMM;
    end
  end

  assign in_ready = !valid_q || bus.out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q   <= 1'b0;
      pc_q      <= RESET_PC;
      q         <= '0;
`ifdef RV32_DECODE_ILLEGAL_EN
      illegal_q <= 1'b0;
`endif
    end else if (bus.flush_in) begin
      valid_q <= 1'b0;
    end else if (in_ready) begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        q         <= dec;
        pc_q      <= bus.pc_in;
`ifdef RV32_DECODE_ILLEGAL_EN
        illegal_q <= bad;
`endif
      end
    end
  end

  assign bus.in_ready        = in_ready;
  assign bus.out_valid       = valid_q;
  assign bus.pc_out          = pc_q;
  assign bus.rs1_out         = q.rs1;
  assign bus.rs2_out         = q.rs2;
  assign bus.rd_out          = q.rd;
  assign bus.rd_write_out    = q.rd_write;
  assign bus.alu_op_out      = q.alu_op;
  assign bus.alu_sub_sra_out = q.sub_sra;
  assign bus.alu_src1_out    = q.src1;
  assign bus.alu_src2_out    = q.src2;
  assign bus.imm_out         = q.imm;
  assign bus.mem_load_out    = q.mem_load;
  assign bus.mem_store_out   = q.mem_store;
  assign bus.branch_out      = q.branch;
  assign bus.jump_out        = q.jump;
`ifdef RV32_DECODE_ILLEGAL_EN
  assign bus.illegal_out     = illegal_q;
`endif

endmodule
